bit_unstuffer: RTL and testbench



---
 rtl/bit_unstuffer.sv | 151 +++++++++++++++
 tb/tb_bit_unstuffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_unstuffer.sv
// -----------------------------------------------------------------------------
// bit_unstuffer
//
// Receive-path stage between the NRZI decoder and bs_decoder. It removes the
// stuffed 0 that follows every run of MAX_ONES consecutive 1s, frames each
// packet with start_decode / end_decode pulses, and qualifies every data bit
// with s_valid. A 1 arriving where a stuffed 0 is expected is reported to
// protocolFSM as stuff_error, which is held until rc_stuff_error acknowledges
// it.
//
// Ports:
//   clk             system clock, all state on the rising edge
//   rst             synchronous, active-high reset
//   abort           synchronous return to IDLE (from protocolFSM)
//   s_in            decoded serial bit, one per cycle while framed
//   start_unstuff   pulse: s_in this cycle is the first bit after SYNC
//   end_unstuff     pulse: EOP detected, s_in not valid this cycle
//   rc_stuff_error  acknowledge of stuff_error
//   s_out           unstuffed bit (0 whenever s_valid is 0)
//   s_valid         s_out carries a real data bit this cycle
//   start_decode    pulse: first bit of the packet
//   end_decode      pulse: packet ended cleanly
//   stuff_error     level until acknowledged
//   unstuffer_wait  high while idle and ready for a packet
//
// Outputs are Mealy (zero latency from s_in to s_out).
// -----------------------------------------------------------------------------
module bit_unstuffer #(
   parameter int MAX_ONES  = 6,
   parameter int SYNC_ONES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic abort,
   input  logic s_in,
   input  logic start_unstuff,
   input  logic end_unstuff,
   input  logic rc_stuff_error,
   output logic s_out,
   output logic s_valid,
   output logic start_decode,
   output logic end_decode,
   output logic stuff_error,
   output logic unstuffer_wait
);

   localparam int CNT_W = $clog2(MAX_ONES + 1);

   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_ONES);
   // The decoded SYNC field ends in SYNC_ONES 1s, so a leading 1 in the
   // first data bit continues that run.
   localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(SYNC_ONES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t           state_reg,    state_next;
   logic [CNT_W-1:0] ones_cnt_reg, ones_cnt_next;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         ones_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         ones_cnt_reg <= ones_cnt_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and Mealy outputs
   // ---------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      ones_cnt_next  = ones_cnt_reg;
      s_out          = 1'b0;
      s_valid        = 1'b0;
      start_decode   = 1'b0;
      end_decode     = 1'b0;
      stuff_error    = 1'b0;
      unstuffer_wait = 1'b0;

      case (state_reg)
         IDLE: begin
            unstuffer_wait = 1'b1;
            if (start_unstuff) begin
               start_decode  = 1'b1;
               s_valid       = 1'b1;
               s_out         = s_in;
               ones_cnt_next = s_in ? SYNC_START : '0;
               state_next    = RUN;
            end
         end

         RUN: begin
            if (end_unstuff) begin
               // EOP wins even when a stuffed bit is due.
               end_decode    = 1'b1;
               ones_cnt_next = '0;
               state_next    = IDLE;
            end else if (ones_cnt_reg == MAX_CNT) begin
               ones_cnt_next = '0;
               if (s_in) begin
                  stuff_error = 1'b1;
                  state_next  = ERROR;
               end
               // s_in == 0: stuffed bit silently dropped.
            end else begin
               s_valid = 1'b1;
               s_out   = s_in;
               // Only reached below MAX_CNT, so the count cannot overflow.
               ones_cnt_next = s_in ? (ones_cnt_reg + CNT_ONE) : '0;
            end
         end

         ERROR: begin
            if (rc_stuff_error) begin
               state_next = IDLE;
            end else begin
               stuff_error = 1'b1;
            end
         end

         default: begin
            state_next    = IDLE;
            ones_cnt_next = '0;
         end
      endcase

      // Reset and abort squash every output and force IDLE; the block is
      // considered idle (ready) while either is asserted.
      if (rst || abort) begin
         s_out          = 1'b0;
         s_valid        = 1'b0;
         start_decode   = 1'b0;
         end_decode     = 1'b0;
         stuff_error    = 1'b0;
         unstuffer_wait = 1'b1;
         state_next     = IDLE;
         ones_cnt_next  = '0;
      end
   end

endmodule

// File: tb/tb_bit_unstuffer.sv
// -----------------------------------------------------------------------------
// tb_bit_unstuffer
//
// Table-driven bench for bit_unstuffer. Each record holds the inputs for one
// cycle and the expected outputs packed as
//   {s_out, s_valid, start_decode, end_decode, stuff_error, unstuffer_wait}.
// Expected records are queued when a cycle is driven and popped when the
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bit_unstuffer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic abort = 1'b0;
   logic s_in = 1'b0;
   logic start_unstuff = 1'b0;
   logic end_unstuff = 1'b0;
   logic rc_stuff_error = 1'b0;
   logic s_out, s_valid, start_decode, end_decode, stuff_error, unstuffer_wait;

   always #5 clk = ~clk;

   bit_unstuffer #(.MAX_ONES(6), .SYNC_ONES(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .abort          (abort),
      .s_in           (s_in),
      .start_unstuff  (start_unstuff),
      .end_unstuff    (end_unstuff),
      .rc_stuff_error (rc_stuff_error),
      .s_out          (s_out),
      .s_valid        (s_valid),
      .start_decode   (start_decode),
      .end_decode     (end_decode),
      .stuff_error    (stuff_error),
      .unstuffer_wait (unstuffer_wait)
   );

   typedef struct {
      int         sec;
      logic [5:0] ins;      // {rst, abort, s_in, start, end, rc}
      logic [5:0] exp;      // {s_out, s_valid, start_dec, end_dec, err, wait}
      logic       chk_wait; // 0: unstuffer_wait not compared this cycle
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t v(input int sec, input logic [5:0] ins,
                              input logic [5:0] exp);
      vec_t t;
      t.sec = sec; t.ins = ins; t.exp = exp; t.chk_wait = 1'b1;
      return t;
   endfunction

   function automatic vec_t vm(input int sec, input logic [5:0] ins,
                               input logic [5:0] exp);
      vec_t t;
      t.sec = sec; t.ins = ins; t.exp = exp; t.chk_wait = 1'b0;
      return t;
   endfunction

   task automatic check_out();
      vec_t       e;
      logic [5:0] act;
      logic [5:0] msk;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: queue empty, actual none required one entry");
         return;
      end
      e   = exp_q.pop_front();
      act = {s_out, s_valid, start_decode, end_decode, stuff_error, unstuffer_wait};
      msk = e.chk_wait ? 6'b111111 : 6'b111110;
      checks++;
      if ((act & msk) !== (e.exp & msk)) begin
         errors++;
         $display("FAIL sec%0d in=%b outputs actual=%b required=%b (mask %b)",
                  e.sec, e.ins, act, e.exp, msk);
      end else begin
         $display("ok   sec%0d in=%b outputs=%b", e.sec, e.ins, act);
      end
   endtask

   task automatic drive(input vec_t t);
      @(posedge clk);
      #1;
      {rst, abort, s_in, start_unstuff, end_unstuff, rc_stuff_error} = t.ins;
      exp_q.push_back(t);
      @(negedge clk);
      check_out();
   endtask

   // Input bit positions: rst abort s_in start end rc
   localparam logic [5:0] I_IDLE = 6'b000000;
   localparam logic [5:0] I_ST1  = 6'b001100;
   localparam logic [5:0] I_ST0  = 6'b000100;
   localparam logic [5:0] I_D1   = 6'b001000;
   localparam logic [5:0] I_D0   = 6'b000000;
   localparam logic [5:0] I_END  = 6'b000010;
   localparam logic [5:0] I_RC   = 6'b000001;
   // Expected: s_out s_valid start end err wait
   localparam logic [5:0] E_WAIT = 6'b000001;
   localparam logic [5:0] E_ST1  = 6'b111001;
   localparam logic [5:0] E_ST0  = 6'b011001;
   localparam logic [5:0] E_V1   = 6'b110000;
   localparam logic [5:0] E_V0   = 6'b010000;
   localparam logic [5:0] E_NONE = 6'b000000;
   localparam logic [5:0] E_END  = 6'b000100;
   localparam logic [5:0] E_ERR  = 6'b000010;

   initial begin
      // ---- 1. reset with random inputs (hand-written) --------------------
      for (int i = 0; i < 2; i++) begin
         logic [4:0] r;
         r = 5'($urandom);
         drive(v(1, {1'b1, r}, E_WAIT));
      end
      drive(v(1, I_IDLE, E_WAIT));

      // ---- 2. clean packet 1,0,1,1,0,0,1,0 -------------------------------
      tbl.push_back(v(2, I_ST1, E_ST1));
      tbl.push_back(v(2, I_D0,  E_V0));
      tbl.push_back(v(2, I_D1,  E_V1));
      tbl.push_back(v(2, I_D1,  E_V1));
      tbl.push_back(v(2, I_D0,  E_V0));
      tbl.push_back(v(2, I_D0,  E_V0));
      tbl.push_back(v(2, I_D1,  E_V1));
      tbl.push_back(v(2, I_D0,  E_V0));
      tbl.push_back(v(2, I_END, E_END));
      tbl.push_back(v(2, I_IDLE, E_WAIT));

      // ---- 3a. stuffing right after SYNC (count starts at 2) -------------
      tbl.push_back(v(3, I_ST1, E_ST1));
      for (int i = 0; i < 4; i++) tbl.push_back(v(3, I_D1, E_V1));
      tbl.push_back(v(3, I_D0,  E_NONE));   // stuffed 0 dropped
      tbl.push_back(v(3, I_D1,  E_V1));
      tbl.push_back(v(3, I_END, E_END));
      // ---- 3b. back-to-back packet, run of six 1s mid-packet -------------
      tbl.push_back(v(3, I_ST0, E_ST0));
      for (int i = 0; i < 6; i++) tbl.push_back(v(3, I_D1, E_V1));
      tbl.push_back(v(3, I_D0,  E_NONE));
      tbl.push_back(v(3, I_D0,  E_V0));
      tbl.push_back(v(3, I_END, E_END));
      tbl.push_back(v(3, I_RC,  E_WAIT));   // rc ignored in IDLE

      // ---- 4. stuff error entry ------------------------------------------
      tbl.push_back(v(4, I_ST1, E_ST1));
      for (int i = 0; i < 4; i++) tbl.push_back(v(4, I_D1, E_V1));
      tbl.push_back(v(4, I_D1,  E_ERR));

      foreach (tbl[i]) drive(tbl[i]);
      tbl.delete();

      // ---- 4 (cont). error held until acknowledge (hand-written) ---------
      for (int i = 0; i < 5; i++) begin
         logic [2:0] r;
         r = 3'($urandom);
         drive(v(4, {2'b00, r, 1'b0}, E_ERR));   // start/end ignored
      end
      drive(v(4, I_RC,   E_NONE));
      drive(v(4, I_IDLE, E_WAIT));

      // ---- 5. end at ones_cnt==6; start ignored mid-RUN -------------------
      tbl.push_back(v(5, I_ST1, E_ST1));
      for (int i = 0; i < 4; i++) tbl.push_back(v(5, I_D1, E_V1));
      tbl.push_back(v(5, 6'b001010, E_END));  // end with s_in=1 at count 6
      tbl.push_back(v(5, I_IDLE, E_WAIT));
      tbl.push_back(v(5, I_ST0, E_ST0));
      tbl.push_back(v(5, I_ST1, E_V1));       // no second start_decode
      tbl.push_back(v(5, I_D0,  E_V0));
      tbl.push_back(v(5, I_END, E_END));

      // ---- 6a. abort on 3rd data bit, immediate restart -------------------
      tbl.push_back(v(6, I_ST1, E_ST1));
      tbl.push_back(v(6, I_D1,  E_V1));
      tbl.push_back(vm(6, 6'b011000, E_NONE));
      tbl.push_back(v(6, I_ST1, E_ST1));
      for (int i = 0; i < 4; i++) tbl.push_back(v(6, I_D1, E_V1));
      tbl.push_back(v(6, I_D0,  E_NONE));     // count restarted at 2
      tbl.push_back(v(6, I_END, E_END));
      // ---- 6b. same with rst ----------------------------------------------
      tbl.push_back(v(6, I_ST0, E_ST0));
      tbl.push_back(v(6, I_D1,  E_V1));
      tbl.push_back(vm(6, 6'b101000, E_NONE));
      tbl.push_back(v(6, I_ST1, E_ST1));
      for (int i = 0; i < 4; i++) tbl.push_back(v(6, I_D1, E_V1));
      tbl.push_back(v(6, I_D0,  E_NONE));
      tbl.push_back(v(6, I_END, E_END));
      tbl.push_back(v(6, I_IDLE, E_WAIT));

      foreach (tbl[i]) drive(tbl[i]);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual %0d left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
